seg_addsub: RTL and testbench
=============================

Name: seg_addsub

Overview:
- Parametrised multi-cycle adder/subtractor; the successor to the fixed 32-bit ripple adder.
- Processes a WIDTH-bit add or subtract in SEG-bit slices, one slice per clock, so the carry chain per cycle is only SEG bits long.
- Valid/ready handshakes on both input and output; result flags (carry, signed overflow, zero) for ALU/datapath use.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SEG (elaboration-time error otherwise).
- SEG, 8, bits added per cycle; 1 <= SEG <= WIDTH.
- Derived NSEG = WIDTH/SEG, the number of RUN cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a-b-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of MSB (sub: 1 = no borrow).
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, zero=0; slice index and internal carry cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clk edge, latch a and b_eff = sub ? ~b : b, and set carry = sub ? ~cin : cin.
  - Clear sum to 0, set index=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: {c, s} = a[idx*SEG +: SEG] + b_eff[idx*SEG +: SEG] + carry.
  - Write s into sum[idx*SEG +: SEG], set carry=c, idx++.
  - After slice NSEG-1: cout=c, overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (both taken inside the last slice), zero = (final sum == 0). Go to DONE.
- DONE:
  - out_valid=1; sum and flags held stable while out_ready=0 (unbounded backpressure).
  - On out_ready=1: out_valid=0 next cycle, go to IDLE.
  - in_ready=0 in DONE; a new operation cannot be accepted in the same cycle the result is taken.
- Latency: out_valid rises exactly NSEG cycles after the accepting edge. Throughput: one operation per NSEG+2 cycles when out_ready is held high.
- Arithmetic is modulo 2^WIDTH; no saturation.
- in_valid, a, b, cin, sub are ignored outside IDLE. Operands are sampled only at the accept edge, so later changes have no effect.
- sum is only meaningful while out_valid=1; during RUN it shows partial slices.
- Reset asserted mid-RUN or in DONE: immediate return to reset values; the in-flight result is lost. After release, in_ready=1 on the first cycle.
- SEG=WIDTH: single RUN cycle (latency 1). SEG=1: bit-serial (latency WIDTH).

Test Plan:
- WIDTH=32, SEG=8: a=0xFFFFFFFF, b=1, cin=0, sub=0 -> out_valid 4 cycles after accept; sum=0, cout=1, zero=1, overflow=0.
- a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, overflow=1, cout=0. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, overflow=1, cout=1.
- Subtract with borrow: a=5, b=7, cin=1, sub=1 -> sum=0xFFFFFFFD, cout=0, overflow=0, zero=0.
- Backpressure: hold out_ready=0 for 6 cycles while toggling in_valid, a, b -> sum/flags constant, in_ready=0, no new accept. out_ready=1 -> out_valid low next cycle, in_ready=1.
- Reset mid-RUN (assert rst_n=0 at slice 2) -> sum=0, out_valid=0, in_ready=1 immediately. A fresh op 3+4 then yields sum=7 after 4 cycles.
- Parameter sweep SEG=32 and SEG=1 (WIDTH=32) with 1000 random ops vs reference model -> results match; latency 1 and 32 respectively.

Source files
------------

// File: rtl/seg_addsub.sv
// seg_addsub: multi-cycle adder/subtractor that walks a WIDTH-bit operation
// through SEG-bit slices, one slice per clock, keeping the carry chain short.
// Valid/ready on both sides; the result carries carry, signed-overflow and
// zero flags for ALU use.
module seg_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NSEG  = WIDTH / SEG;
  localparam int IDXW  = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int BASEW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSEG - 1);

  // Reject slice sizes that do not tile the operand exactly.
  generate
    if (SEG < 1 || SEG > WIDTH || (WIDTH % SEG) != 0) begin : g_bad_params
      $error("seg_addsub: WIDTH must be a positive multiple of SEG");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [BASEW-1:0] base;
  logic [SEG-1:0]   slice_a;
  logic [SEG-1:0]   slice_b;
  logic [SEG-1:0]   slice_s;
  logic             slice_c;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  // One SEG-bit slice add; overflow uses the MSB carry-in recovered as a^b^s.
  always_comb begin
    base    = BASEW'(idx_q) * BASEW'(SEG);
    slice_a = a_q[base +: SEG];
    slice_b = b_q[base +: SEG];
    {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{SEG{1'b0}}, carry_q};
    sum_d   = sum_q;
    sum_d[base +: SEG] = slice_s;
    ovf_d   = slice_a[SEG-1] ^ slice_b[SEG-1] ^ slice_s[SEG-1] ^ slice_c;
  end

  // Control FSM with registered handshake outputs, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry_q    <= sub ? ~cin : cin;
            sum_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_c;
          idx_q   <= idx_q + IDXW'(1);
          if (idx_q == LAST_IDX) begin
            cout_q      <= slice_c;
            ovf_q       <= ovf_d;
            zero_q      <= (sum_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seg_addsub.sv
// tb_seg_addsub: directed and reference-model checks of seg_addsub with
// SEG=8, SEG=32 and SEG=1 instances sharing one set of input drivers.
module tb_seg_addsub;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic [31:0] aIn;
  logic [31:0] bIn;
  logic        cinIn;
  logic        subIn;
  logic        outReady;

  logic        inReadyW [3];
  logic        outValidW[3];
  logic [31:0] sumW     [3];
  logic        coutW    [3];
  logic        ovfW     [3];
  logic        zeroW    [3];

  int checkCount;
  int errorCount;

  logic [31:0] rSum;
  logic        rCout;
  logic        rOvf;
  logic        rZero;
  int          rLat;

  seg_addsub #(.WIDTH(32), .SEG(8)) uSeg8 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReadyW[0]),
    .a(aIn), .b(bIn), .cin(cinIn), .sub(subIn),
    .out_valid(outValidW[0]), .out_ready(outReady), .sum(sumW[0]),
    .cout(coutW[0]), .overflow(ovfW[0]), .zero(zeroW[0])
  );

  seg_addsub #(.WIDTH(32), .SEG(32)) uSeg32 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReadyW[1]),
    .a(aIn), .b(bIn), .cin(cinIn), .sub(subIn),
    .out_valid(outValidW[1]), .out_ready(outReady), .sum(sumW[1]),
    .cout(coutW[1]), .overflow(ovfW[1]), .zero(zeroW[1])
  );

  seg_addsub #(.WIDTH(32), .SEG(1)) uSeg1 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReadyW[2]),
    .a(aIn), .b(bIn), .cin(cinIn), .sub(subIn),
    .out_valid(outValidW[2]), .out_ready(outReady), .sum(sumW[2]),
    .cout(coutW[2]), .overflow(ovfW[2]), .zero(zeroW[2])
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never finishes.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: signed/unsigned arithmetic in 64 bits.
  // Returns {zero, overflow, cout, sum}.
  function automatic logic [34:0] refModel(input logic [31:0] x, input logic [31:0] y,
                                           input logic c, input logic s);
    longint sx, sy, sr, ur, cl;
    logic [31:0] res;
    logic co, ov;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    cl = c ? 64'sd1 : 64'sd0;
    if (!s) begin
      ur  = longint'(x) + longint'(y) + cl;
      co  = ur[32];
      sr  = sx + sy + cl;
    end else begin
      ur  = longint'(x) - longint'(y) - cl;
      co  = (longint'(x) >= longint'(y) + cl);
      sr  = sx - sy - cl;
    end
    res = ur[31:0];
    ov  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {(res == 32'h0), ov, co, res};
  endfunction

  // Present one operation to instance k, wait for accept then for out_valid.
  // gotLat is -1 if never accepted; 200 if the result never appeared.
  task automatic applyStimulus(input int k, input logic [31:0] aV, input logic [31:0] bV,
                               input logic cinV, input logic subV, input logic holdOut,
                               output logic [31:0] gotSum, output logic gotCout,
                               output logic gotOvf, output logic gotZero, output int gotLat);
    int n;
    outReady = ~holdOut;
    aIn      = aV;
    bIn      = bV;
    cinIn    = cinV;
    subIn    = subV;
    inValid  = 1'b1;
    n = 0;
    while (!inReadyW[k] && n < 200) begin
      tick();
      n++;
    end
    gotSum = 32'h0; gotCout = 1'b0; gotOvf = 1'b0; gotZero = 1'b0;
    if (!inReadyW[k]) begin
      inValid = 1'b0;
      gotLat  = -1;
      return;
    end
    tick();
    inValid = 1'b0;
    gotLat  = 0;
    while (!outValidW[k] && gotLat < 200) begin
      tick();
      gotLat++;
    end
    gotSum  = sumW[k];
    gotCout = coutW[k];
    gotOvf  = ovfW[k];
    gotZero = zeroW[k];
  endtask

  // Take the pending result from instance 0 and return it to IDLE.
  task automatic releaseResult();
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
  endtask

  // Reset values on every instance and in_ready right after release.
  task automatic test_reset();
    rstN = 1'b0; inValid = 1'b0; outReady = 1'b0;
    aIn = 32'h0; bIn = 32'h0; cinIn = 1'b0; subIn = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      checkCount++; if (inReadyW[k] !== 1'b1) begin errorCount++; $display("[TB] FAIL reset.inReady[%0d] got %b expected 1", k, inReadyW[k]); end
      checkCount++; if (outValidW[k] !== 1'b0) begin errorCount++; $display("[TB] FAIL reset.outValid[%0d] got %b expected 0", k, outValidW[k]); end
      checkCount++; if ({sumW[k], coutW[k], ovfW[k], zeroW[k]} !== 35'h0) begin errorCount++;
        $display("[TB] FAIL reset.result[%0d] got sum=%h c=%b v=%b z=%b expected all 0", k, sumW[k], coutW[k], ovfW[k], zeroW[k]); end
    end
    rstN = 1'b1;
    tick();
    checkCount++; if (inReadyW[0] !== 1'b1) begin errorCount++; $display("[TB] FAIL reset.inReadyAfter got %b expected 1", inReadyW[0]); end
  endtask

  // 0xFFFFFFFF + 1 wraps to zero with carry out.
  task automatic test_add_carry();
    applyStimulus(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, rSum, rCout, rOvf, rZero, rLat);
    checkCount++; if (rLat !== 4) begin errorCount++; $display("[TB] FAIL addCarry.latency got %0d expected 4", rLat); end
    checkCount++; if (rSum !== 32'h0) begin errorCount++; $display("[TB] FAIL addCarry.sum got %h expected 00000000", rSum); end
    checkCount++; if (rCout !== 1'b1) begin errorCount++; $display("[TB] FAIL addCarry.cout got %b expected 1", rCout); end
    checkCount++; if (rOvf !== 1'b0) begin errorCount++; $display("[TB] FAIL addCarry.overflow got %b expected 0", rOvf); end
    checkCount++; if (rZero !== 1'b1) begin errorCount++; $display("[TB] FAIL addCarry.zero got %b expected 1", rZero); end
    releaseResult();
  endtask

  // Signed overflow in both directions.
  task automatic test_signed_overflow();
    applyStimulus(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, rSum, rCout, rOvf, rZero, rLat);
    checkCount++; if (rSum !== 32'h8000_0000) begin errorCount++; $display("[TB] FAIL ovfAdd.sum got %h expected 80000000", rSum); end
    checkCount++; if (rOvf !== 1'b1) begin errorCount++; $display("[TB] FAIL ovfAdd.overflow got %b expected 1", rOvf); end
    checkCount++; if (rCout !== 1'b0) begin errorCount++; $display("[TB] FAIL ovfAdd.cout got %b expected 0", rCout); end
    checkCount++; if (rZero !== 1'b0) begin errorCount++; $display("[TB] FAIL ovfAdd.zero got %b expected 0", rZero); end
    releaseResult();
    applyStimulus(0, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1, rSum, rCout, rOvf, rZero, rLat);
    checkCount++; if (rSum !== 32'h7FFF_FFFF) begin errorCount++; $display("[TB] FAIL ovfSub.sum got %h expected 7fffffff", rSum); end
    checkCount++; if (rOvf !== 1'b1) begin errorCount++; $display("[TB] FAIL ovfSub.overflow got %b expected 1", rOvf); end
    checkCount++; if (rCout !== 1'b1) begin errorCount++; $display("[TB] FAIL ovfSub.cout got %b expected 1", rCout); end
    releaseResult();
  endtask

  // 5 - 7 - 1 = -3 with a borrow, plus 0 - 0 giving zero and no borrow.
  task automatic test_sub_borrow();
    applyStimulus(0, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1, rSum, rCout, rOvf, rZero, rLat);
    checkCount++; if (rSum !== 32'hFFFF_FFFD) begin errorCount++; $display("[TB] FAIL subBorrow.sum got %h expected fffffffd", rSum); end
    checkCount++; if (rCout !== 1'b0) begin errorCount++; $display("[TB] FAIL subBorrow.cout got %b expected 0", rCout); end
    checkCount++; if (rOvf !== 1'b0) begin errorCount++; $display("[TB] FAIL subBorrow.overflow got %b expected 0", rOvf); end
    checkCount++; if (rZero !== 1'b0) begin errorCount++; $display("[TB] FAIL subBorrow.zero got %b expected 0", rZero); end
    releaseResult();
    applyStimulus(0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, rSum, rCout, rOvf, rZero, rLat);
    checkCount++; if ({rSum, rCout, rOvf, rZero} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin errorCount++;
      $display("[TB] FAIL subZero.result got sum=%h c=%b v=%b z=%b expected sum=0 c=1 v=0 z=1", rSum, rCout, rOvf, rZero); end
    releaseResult();
  endtask

  // Result held under backpressure while inputs churn; release reopens input.
  task automatic test_backpressure();
    applyStimulus(0, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 1'b1, rSum, rCout, rOvf, rZero, rLat);
    for (int i = 0; i < 6; i++) begin
      inValid = ~inValid;
      aIn = $urandom;
      bIn = $urandom;
      tick();
      checkCount++; if (outValidW[0] !== 1'b1) begin errorCount++; $display("[TB] FAIL backpressure.outValid cycle %0d got %b expected 1", i, outValidW[0]); end
      checkCount++; if (inReadyW[0] !== 1'b0) begin errorCount++; $display("[TB] FAIL backpressure.inReady cycle %0d got %b expected 0", i, inReadyW[0]); end
      checkCount++; if ({sumW[0], coutW[0], ovfW[0], zeroW[0]} !== {32'h31, 3'b000}) begin errorCount++;
        $display("[TB] FAIL backpressure.hold cycle %0d got sum=%h c=%b v=%b z=%b expected sum=31 flags 0", i, sumW[0], coutW[0], ovfW[0], zeroW[0]); end
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    inValid  = 1'b0;
    checkCount++; if (outValidW[0] !== 1'b0) begin errorCount++; $display("[TB] FAIL backpressure.outValidAfter got %b expected 0", outValidW[0]); end
    checkCount++; if (inReadyW[0] !== 1'b1) begin errorCount++; $display("[TB] FAIL backpressure.inReadyAfter got %b expected 1", inReadyW[0]); end
    tick();
    checkCount++; if (inReadyW[0] !== 1'b1) begin errorCount++; $display("[TB] FAIL backpressure.noAccept got %b expected 1", inReadyW[0]); end
  endtask

  // With out_ready held high, accepts are NSEG+2 = 6 cycles apart.
  task automatic test_back_to_back();
    int gap;
    int validCycles;
    outReady = 1'b1;
    aIn = 32'h1; bIn = 32'h2; cinIn = 1'b0; subIn = 1'b0;
    inValid = 1'b1;
    checkCount++; if (inReadyW[0] !== 1'b1) begin errorCount++; $display("[TB] FAIL backToBack.readyStart got %b expected 1", inReadyW[0]); end
    tick();
    gap = 0;
    validCycles = 0;
    while (!inReadyW[0] && gap < 50) begin
      tick();
      gap++;
      if (outValidW[0]) validCycles++;
    end
    checkCount++; if (gap !== 5) begin errorCount++; $display("[TB] FAIL backToBack.gap got %0d expected 5", gap); end
    checkCount++; if (validCycles !== 1) begin errorCount++; $display("[TB] FAIL backToBack.validCycles got %0d expected 1", validCycles); end
    aIn = 32'h1; bIn = 32'h2;
    tick();
    inValid = 1'b0;
    rLat = 0;
    while (!outValidW[0] && rLat < 50) begin
      tick();
      rLat++;
    end
    checkCount++; if (rLat !== 4) begin errorCount++; $display("[TB] FAIL backToBack.latency2 got %0d expected 4", rLat); end
    checkCount++; if (sumW[0] !== 32'h3) begin errorCount++; $display("[TB] FAIL backToBack.sum2 got %h expected 00000003", sumW[0]); end
    tick();
    outReady = 1'b0;
  endtask

  // Async reset while slice 2 is pending, then a fresh 3+4.
  task automatic test_reset_mid_run();
    aIn = 32'h1234_5678; bIn = 32'h1111_1111; cinIn = 1'b0; subIn = 1'b0;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    tick();
    tick();
    checkCount++; if (sumW[0] !== 32'h0000_6789) begin errorCount++; $display("[TB] FAIL midRun.partialSum got %h expected 00006789", sumW[0]); end
    rstN = 1'b0;
    #1;
    checkCount++; if (sumW[0] !== 32'h0) begin errorCount++; $display("[TB] FAIL midRun.sumReset got %h expected 00000000", sumW[0]); end
    checkCount++; if (outValidW[0] !== 1'b0) begin errorCount++; $display("[TB] FAIL midRun.outValidReset got %b expected 0", outValidW[0]); end
    checkCount++; if (inReadyW[0] !== 1'b1) begin errorCount++; $display("[TB] FAIL midRun.inReadyReset got %b expected 1", inReadyW[0]); end
    #2;
    rstN = 1'b1;
    tick();
    checkCount++; if (inReadyW[0] !== 1'b1) begin errorCount++; $display("[TB] FAIL midRun.inReadyAfter got %b expected 1", inReadyW[0]); end
    applyStimulus(0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, rSum, rCout, rOvf, rZero, rLat);
    checkCount++; if (rLat !== 4) begin errorCount++; $display("[TB] FAIL midRun.freshLatency got %0d expected 4", rLat); end
    checkCount++; if ({rSum, rCout, rOvf, rZero} !== {32'd7, 3'b000}) begin errorCount++;
      $display("[TB] FAIL midRun.freshResult got sum=%h c=%b v=%b z=%b expected sum=7 flags 0", rSum, rCout, rOvf, rZero); end
    releaseResult();
  endtask

  // Random operations on instance k against the reference model.
  task automatic test_param_sweep(input int k, input int expLat);
    logic [31:0] x, y;
    logic c, s;
    logic [34:0] exp;
    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      y = $urandom;
      c = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      if (i % 16 == 0) x = 32'hFFFF_FFFF;
      if (i % 16 == 1) begin x = 32'h8000_0000; y = 32'h8000_0000; end
      if (i % 16 == 2) y = x;
      exp = refModel(x, y, c, s);
      applyStimulus(k, x, y, c, s, 1'b0, rSum, rCout, rOvf, rZero, rLat);
      checkCount++; if (rLat !== expLat) begin errorCount++; $display("[TB] FAIL sweep%0d.latency op %0d got %0d expected %0d", k, i, rLat, expLat); end
      checkCount++; if ({rZero, rOvf, rCout, rSum} !== exp) begin errorCount++;
        $display("[TB] FAIL sweep%0d.result op %0d a=%h b=%h cin=%b sub=%b got z/v/c/sum=%h expected %h", k, i, x, y, c, s, {rZero, rOvf, rCout, rSum}, exp); end
    end
    outReady = 1'b0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    checkCount = 0;
    errorCount = 0;
    test_reset();
    test_add_carry();
    test_signed_overflow();
    test_sub_borrow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_param_sweep(1, 1);
    test_param_sweep(2, 32);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
